// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port BRAM between instruction fetch and data ports, with tagged read return.
// Optional MEM_ARB_PERF_EN macro adds perf_conflict / perf_starve counters.
module mem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wea,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wea,
    input  logic [31:0]       mem_rdata,
    output logic              stall_f
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_conflict,
    output logic [15:0]       perf_starve
`endif
);

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0]         r_starve_cnt;
    logic [MEM_LAT-1:0] r_tag_vld;
    logic [MEM_LAT-1:0] r_tag_own_d;
    logic               w_force_i;
    logic               w_push_vld;
    logic               w_unused_addr;

    assign w_force_i = i_req && (r_starve_cnt == LP_STARVE_MAX);

    // NOTE: grants are combinational, so they are gated by rst to keep every output at 0 during reset.
    always_comb begin
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wea   = '0;
        if (rst) begin
            if (i_req && (w_force_i || !d_req)) begin
                i_gnt    = 1'b1;
                mem_en   = 1'b1;
                mem_addr = i_addr[ADDR_W+1:2];
            end else if (d_req) begin
                d_gnt    = 1'b1;
                mem_en   = 1'b1;
                mem_addr = d_addr[ADDR_W+1:2];
                mem_wea  = d_wea;
                if (d_wea != 4'b0000) begin
                    mem_wdata = d_wdata;
                end
            end
        end
    end

    assign stall_f    = rst && i_req && !i_gnt;
    assign w_push_vld = i_gnt || (d_gnt && (d_wea == 4'b0000));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (i_req && !i_gnt) begin
            if (r_starve_cnt != LP_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // NOTE: non-blocking assignments let every stage shift from its pre-edge value in one pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld   <= '0;
            r_tag_own_d <= '0;
        end else begin
            r_tag_vld[0]   <= w_push_vld;
            r_tag_own_d[0] <= d_gnt;
            for (int k = 1; k < MEM_LAT; k++) begin
                r_tag_vld[k]   <= r_tag_vld[k-1];
                r_tag_own_d[k] <= r_tag_own_d[k-1];
            end
        end
    end

    assign i_rvalid = r_tag_vld[MEM_LAT-1] && !r_tag_own_d[MEM_LAT-1];
    assign d_rvalid = r_tag_vld[MEM_LAT-1] &&  r_tag_own_d[MEM_LAT-1];
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

    // Byte-offset and high address bits are not used by the word-addressed memory.
    assign w_unused_addr = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflict <= '0;
            perf_starve   <= '0;
        end else begin
            if (i_req && d_req) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
            if (i_gnt && w_force_i && (perf_starve != 16'hFFFF)) begin
                perf_starve <= perf_starve + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: one DUT at MEM_LAT=1, one at MEM_LAT=3,
// each with a write-first behavioural BRAM.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wea;

    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, stall_f;
    logic [31:0] i_rdata, d_rdata, mem_wdata, m1_rdata;
    logic [13:0] mem_addr;
    logic [3:0]  mem_wea;

    logic        t3_i_gnt, t3_i_rvalid, t3_d_gnt, t3_d_rvalid, t3_mem_en, t3_stall_f;
    logic [31:0] t3_i_rdata, t3_d_rdata, t3_mem_wdata, m3_rdata;
    logic [13:0] t3_mem_addr;
    logic [3:0]  t3_mem_wea;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conflict, t3_perf_conflict;
    logic [15:0] perf_starve, t3_perf_starve;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(14), .MEM_LAT(1), .STARVE_MAX(3)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wea(d_wea),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wea(mem_wea),
        .mem_rdata(m1_rdata), .stall_f(stall_f)
`ifdef MEM_ARB_PERF_EN
        , .perf_conflict(perf_conflict), .perf_starve(perf_starve)
`endif
    );

    mem_port_arbiter #(.ADDR_W(14), .MEM_LAT(3), .STARVE_MAX(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(t3_i_gnt), .i_rvalid(t3_i_rvalid), .i_rdata(t3_i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wea(d_wea),
        .d_gnt(t3_d_gnt), .d_rvalid(t3_d_rvalid), .d_rdata(t3_d_rdata),
        .mem_en(t3_mem_en), .mem_addr(t3_mem_addr), .mem_wdata(t3_mem_wdata), .mem_wea(t3_mem_wea),
        .mem_rdata(m3_rdata), .stall_f(t3_stall_f)
`ifdef MEM_ARB_PERF_EN
        , .perf_conflict(t3_perf_conflict), .perf_starve(t3_perf_starve)
`endif
    );

    // Behavioural write-first BRAMs.
    logic [31:0] mem1 [0:16383];
    logic [31:0] mem3 [0:16383];
    logic [31:0] w1, w3, m3_q0, m3_q1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            w1 = merge(mem1[mem_addr], mem_wdata, mem_wea);
            mem1[mem_addr] <= w1;
            m1_rdata       <= w1;
        end
    end

    always @(posedge clk) begin
        if (t3_mem_en) begin
            w3 = merge(mem3[t3_mem_addr], t3_mem_wdata, t3_mem_wea);
            mem3[t3_mem_addr] <= w3;
            m3_q0             <= w3;
        end
        m3_q1    <= m3_q0;
        m3_rdata <= m3_q1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_req = 1'b0; d_req = 1'b0; d_wea = 4'b0000;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic preload();
        mem1[14'h008] = 32'h11223344; mem3[14'h008] = 32'h11223344;
        mem1[14'h010] = 32'h00000013; mem3[14'h010] = 32'h00000013;
        mem1[14'h011] = 32'h00000093; mem3[14'h011] = 32'h00000093;
        mem1[14'h040] = 32'hD00D0040; mem3[14'h040] = 32'hD00D0040;
        mem1[14'h041] = 32'hD00D0041; mem3[14'h041] = 32'hD00D0041;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_addr = 32'h100;
        d_wdata = 32'hFFFF_FFFF; d_wea = 4'b1111;
        @(negedge clk);
        n_cmp++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, stall_f} !== 6'b0) begin
            n_mis++;
            $display("FAIL reset_ctrl got=%b exp=000000", {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, stall_f});
        end
        n_cmp++;
        if ({mem_wea, mem_addr, mem_wdata} !== 50'b0) begin
            n_mis++;
            $display("FAIL reset_mem got wea=%b addr=%h wdata=%h exp all 0", mem_wea, mem_addr, mem_wdata);
        end
        n_cmp++;
        if ((i_rdata !== m1_rdata) || (d_rdata !== m1_rdata)) begin
            n_mis++;
            $display("FAIL reset_rdata got i=%h d=%h exp=%h", i_rdata, d_rdata, m1_rdata);
        end
        step();
        idle(1);
        rst = 1'b1;
        step();
    endtask

    task automatic test_fetch_only();
        logic exp_g, exp_v;
        for (int c = 0; c < 5; c++) begin
            i_req = (c < 3); i_addr = 32'h40; d_req = 1'b0;
            @(negedge clk);
            exp_g = (c < 3);
            exp_v = (c >= 1) && (c <= 3);
            n_cmp++;
            if ({i_gnt, d_gnt, stall_f, mem_en} !== {exp_g, 1'b0, 1'b0, exp_g}) begin
                n_mis++;
                $display("FAIL fetch_gnt c=%0d got=%b exp=%b", c, {i_gnt, d_gnt, stall_f, mem_en}, {exp_g, 2'b00, exp_g});
            end
            if (exp_g) begin
                n_cmp++;
                if (mem_addr !== 14'h010) begin
                    n_mis++;
                    $display("FAIL fetch_addr c=%0d got=%h exp=010", c, mem_addr);
                end
            end
            n_cmp++;
            if ({i_rvalid, d_rvalid} !== {exp_v, 1'b0}) begin
                n_mis++;
                $display("FAIL fetch_rvalid c=%0d got=%b exp=%b", c, {i_rvalid, d_rvalid}, {exp_v, 1'b0});
            end
            if (exp_v) begin
                n_cmp++;
                if (i_rdata !== 32'h00000013) begin
                    n_mis++;
                    $display("FAIL fetch_rdata c=%0d got=%h exp=00000013", c, i_rdata);
                end
            end
            step();
        end
    endtask

    task automatic test_conflict();
        logic [7:0] dpat;
        logic       ed, ei, edv, eiv;
        dpat = 8'b0111_0111;
        for (int c = 0; c < 9; c++) begin
            i_req = (c < 8); d_req = (c < 8); i_addr = 32'h40; d_addr = 32'h100; d_wea = 4'b0000;
            @(negedge clk);
            ed  = (c < 8) && dpat[c % 8];
            ei  = (c < 8) && !dpat[c % 8];
            edv = (c >= 1) && dpat[(c + 7) % 8];
            eiv = (c >= 1) && !dpat[(c + 7) % 8];
            n_cmp++;
            if ({d_gnt, i_gnt, stall_f} !== {ed, ei, ed}) begin
                n_mis++;
                $display("FAIL conflict_gnt c=%0d got dgnt/ignt/stall=%b exp=%b", c, {d_gnt, i_gnt, stall_f}, {ed, ei, ed});
            end
            n_cmp++;
            if ({d_rvalid, i_rvalid} !== {edv, eiv}) begin
                n_mis++;
                $display("FAIL conflict_rvalid c=%0d got d/i=%b exp=%b", c, {d_rvalid, i_rvalid}, {edv, eiv});
            end
            if (edv || eiv) begin
                n_cmp++;
                if (m1_rdata !== (edv ? 32'hD00D0040 : 32'h00000013)) begin
                    n_mis++;
                    $display("FAIL conflict_rdata c=%0d got=%h exp=%h", c, m1_rdata, edv ? 32'hD00D0040 : 32'h00000013);
                end
            end
            step();
        end
    endtask

    task automatic test_write_read();
        d_req = 1'b1; d_addr = 32'h20; d_wea = 4'b0011; d_wdata = 32'hAABBCCDD; i_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, mem_en, mem_wea, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 14'h008, 32'hAABBCCDD}) begin
            n_mis++;
            $display("FAIL write_issue got gnt=%b en=%b wea=%b addr=%h wdata=%h exp 1 1 0011 008 aabbccdd",
                     d_gnt, mem_en, mem_wea, mem_addr, mem_wdata);
        end
        step();
        d_wea = 4'b0000; d_wdata = 32'h0;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, mem_wea, d_rvalid, i_rvalid} !== {1'b1, 4'b0000, 1'b0, 1'b0}) begin
            n_mis++;
            $display("FAIL read_issue got gnt=%b wea=%b drv=%b irv=%b exp 1 0000 0 0", d_gnt, mem_wea, d_rvalid, i_rvalid);
        end
        step();
        d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h1122CCDD}) begin
            n_mis++;
            $display("FAIL raw_rdata got rvalid=%b data=%h exp 1 1122ccdd", d_rvalid, d_rdata);
        end
        step();
    endtask

    task automatic test_alternate_lat3();
        logic [6:0]  iseq, dseq, ivseq, dvseq;
        logic [31:0] ia [0:6];
        logic [31:0] da [0:6];
        logic [31:0] ed [0:6];
        iseq  = 7'b0000101; dseq  = 7'b0001010;
        ivseq = 7'b0101000; dvseq = 7'b1010000;
        ia[0] = 32'h40; ia[2] = 32'h44; da[1] = 32'h100; da[3] = 32'h104;
        ed[3] = 32'h00000013; ed[4] = 32'hD00D0040; ed[5] = 32'h00000093; ed[6] = 32'hD00D0041;
        for (int c = 0; c < 7; c++) begin
            i_req = iseq[c]; d_req = dseq[c]; d_wea = 4'b0000;
            if (iseq[c]) i_addr = ia[c];
            if (dseq[c]) d_addr = da[c];
            @(negedge clk);
            n_cmp++;
            if ({t3_i_gnt, t3_d_gnt} !== {iseq[c], dseq[c]}) begin
                n_mis++;
                $display("FAIL lat3_gnt c=%0d got i/d=%b exp=%b", c, {t3_i_gnt, t3_d_gnt}, {iseq[c], dseq[c]});
            end
            n_cmp++;
            if ({t3_i_rvalid, t3_d_rvalid} !== {ivseq[c], dvseq[c]}) begin
                n_mis++;
                $display("FAIL lat3_rvalid c=%0d got i/d=%b exp=%b", c, {t3_i_rvalid, t3_d_rvalid}, {ivseq[c], dvseq[c]});
            end
            if (ivseq[c] || dvseq[c]) begin
                n_cmp++;
                if ((ivseq[c] ? t3_i_rdata : t3_d_rdata) !== ed[c]) begin
                    n_mis++;
                    $display("FAIL lat3_rdata c=%0d got=%h exp=%h", c, ivseq[c] ? t3_i_rdata : t3_d_rdata, ed[c]);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_midflight();
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_addr = 32'h100; d_wea = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({d_gnt, i_gnt} !== 2'b10) begin
                n_mis++;
                $display("FAIL pre_reset_gnt c=%0d got d/i=%b exp=10", c, {d_gnt, i_gnt});
            end
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_wea, stall_f} !== 10'b0) begin
            n_mis++;
            $display("FAIL midflight_outputs got=%b exp=0000000000",
                     {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_wea, stall_f});
        end
        step();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_cmp++;
                if ({i_rvalid, d_rvalid} !== 2'b00) begin
                    n_mis++;
                    $display("FAIL dropped_rvalid got i/d=%b exp=00", {i_rvalid, d_rvalid});
                end
            end
            n_cmp++;
            if ({d_gnt, i_gnt} !== ((c < 3) ? 2'b10 : 2'b01)) begin
                n_mis++;
                $display("FAIL post_reset_gnt c=%0d got d/i=%b exp=%b", c, {d_gnt, i_gnt}, (c < 3) ? 2'b10 : 2'b01);
            end
            step();
        end
        idle(4);
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic test_perf();
        idle(1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_addr = 32'h100; d_wea = 4'b0000;
        for (int c = 0; c < 5; c++) step();
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (perf_conflict !== 32'd5) begin
            n_mis++;
            $display("FAIL perf_conflict got=%0d exp=5", perf_conflict);
        end
        n_cmp++;
        if (perf_starve !== 16'd1) begin
            n_mis++;
            $display("FAIL perf_starve got=%0d exp=1", perf_starve);
        end
        step();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preload();
        test_reset();
        test_fetch_only();
        idle(2);
        test_conflict();
        idle(2);
        test_write_read();
        idle(4);
        test_alternate_lat3();
        idle(2);
        test_reset_midflight();
`ifdef MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory (BRAM, fixed read latency) between the core's instruction-fetch port and its data (M-stage) port.
- Resolves the structural hazard by arbitrating per cycle and returning read data tagged to the right requester after the memory latency.
- Asserts a fetch stall toward the hazard logic whenever fetch is denied.
- Sits between riscv_core and the shared imem/dmem BRAM.

Parameters:
- ADDR_W, 14, memory word-address width; mem_addr = req_addr[ADDR_W+1:2].
- MEM_LAT, 1, memory read latency in cycles (1..4).
- STARVE_MAX, 3, consecutive fetch denials before fetch is forced to win one cycle (1..15).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- i_req  input  1  fetch read request
- i_addr  input  32  fetch byte address
- i_gnt  output  1  fetch accepted this cycle
- i_rvalid  output  1  fetch read data valid
- i_rdata  output  32  fetch read data
- d_req  input  1  data request (read or write)
- d_addr  input  32  data byte address
- d_wdata  input  32  write data
- d_wea  input  4  byte write enables; 0 = read
- d_gnt  output  1  data accepted this cycle
- d_rvalid  output  1  data read data valid (reads only)
- d_rdata  output  32  data read data
- mem_en  output  1  memory enable
- mem_addr  output  ADDR_W  memory word address
- mem_wdata  output  32  memory write data
- mem_wea  output  4  memory byte write enables
- mem_rdata  input  32  memory read data, MEM_LAT cycles after mem_en
- stall_f  output  1  i_req && !i_gnt

Behaviour:
- Grant is combinational in the request cycle; exactly one issue per cycle max; i_gnt and d_gnt never both 1.
- Priority: data wins (older instruction).
  - Exception: when starve_cnt == STARVE_MAX and i_req=1, fetch wins and d_gnt=0.
- starve_cnt (4-bit):
  - increments when i_req && !i_gnt, saturating at STARVE_MAX;
  - clears on i_gnt or when !i_req.
- Issue: the granted port drives mem_addr and mem_en=1.
  - Write (d_wea != 0): mem_wea=d_wea, mem_wdata=d_wdata; no rvalid generated.
  - Otherwise mem_wea=0.
  - No grant: mem_en=0, mem_wea=0, mem_addr/mem_wdata=0.
- Return tag pipeline: MEM_LAT-deep shift register of {valid, owner}. A read issue pushes {1, I or D}; otherwise it pushes {0, x}.
  - At the tail, i_rvalid or d_rvalid pulses for exactly one cycle, MEM_LAT cycles after grant.
  - i_rdata and d_rdata both equal mem_rdata combinationally; only the rvalid qualifies.
- Back-to-back grants allowed every cycle; read and write order to the memory equals grant order.
  - Read-after-write to the same address returns the new data (the memory handles this in write-first mode).
- Requests are level; a requester holds req/addr/data stable until it sees gnt.
- Reset (rst=0, any time, including mid-transfer):
  - tag pipeline cleared, starve_cnt=0;
  - all outputs 0 (i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_wea, stall_f); rdata outputs follow mem_rdata;
  - in-flight reads are dropped with no rvalid.
- After reset deasserts, the first grant can occur in the same cycle as a request.

Optional Feature:
- Macro: MEM_ARB_PERF_EN
- Defined:
  - adds output perf_conflict [31:0], counting cycles with i_req && d_req both 1 (wraps at 2^32, cleared by reset);
  - adds output perf_starve [15:0], counting forced fetch-priority grants (saturates at 16'hFFFF).
- Undefined: neither port nor counter exists; arbitration is identical.

Test Plan:
1. Fetch only, MEM_LAT=1: i_req=1, i_addr=0x40 for 3 cycles, memory word 0x10 preloaded with 0x00000013.
   - Expected: i_gnt=1 every cycle, mem_addr=0x10, i_rvalid=1 one cycle later with i_rdata=0x00000013, stall_f=0.
2. Conflict, STARVE_MAX=3: i_req and d_req (read, d_addr=0x100) held 1 continuously.
   - Expected grant pattern D,D,D,I repeating; stall_f=1 on D cycles; each d_rvalid/i_rvalid arrives 1 cycle after its grant with the correct owner.
3. Write then read: d_req write d_addr=0x20, d_wea=4'b0011, d_wdata=0xAABBCCDD; next cycle read 0x20 over old 0x11223344.
   - Expected: mem_wea=0011, no d_rvalid for the write, then d_rdata=0x1122CCDD.
4. MEM_LAT=3, alternating I and D reads on consecutive cycles.
   - Expected: rvalids appear 3 cycles later in the same alternating order, never both in one cycle.
5. Reset mid-flight: grant a read, drop rst to 0 for 1 cycle before data return.
   - Expected: no rvalid, all outputs 0 during reset, starve_cnt=0 (next conflict grants D first).
6. With MEM_ARB_PERF_EN: 5 cycles of simultaneous requests.
   - Expected: perf_conflict=5, perf_starve=1 (STARVE_MAX=3).
